// File: rtl/hdc_pkg.sv
// Shared types and helpers for the hypervector bundler slice.
// Holds the bundler FSM state type and the tie-break helper.
package hdc_pkg;

    typedef enum logic [1:0] {
        ACC,
        EVAL,
        OUT
    } bundler_state_t;

    // An exact tie is only possible when an even number of HVs is bundled.
    function automatic bit tie_needed(int n);
        return (n % 2) == 0;
    endfunction

endpackage

// File: rtl/bundler_hv_seq_if.sv
// Handshake bundle for the sequential HV bundler.
// master: drives in_valid/in_hv/tie_hv/out_ready; slave: drives in_ready/out_valid/out_hv.
interface bundler_hv_seq_if #(
    parameter int DIM = 64
);
    logic           in_valid;
    logic           in_ready;
    logic [DIM-1:0] in_hv;
    logic [DIM-1:0] tie_hv;
    logic           out_valid;
    logic           out_ready;
    logic [DIM-1:0] out_hv;

    modport master (
        output in_valid, in_hv, tie_hv, out_ready,
        input  in_ready, out_valid, out_hv
    );

    modport slave (
        input  in_valid, in_hv, tie_hv, out_ready,
        output in_ready, out_valid, out_hv
    );
endinterface

// File: rtl/bundler_cnt_bit.sv
// One bit slice of the bundler: ones-counter, captured tie bit, majority register.
// Ports: clk, rst, load, inc_en, bit_in, tie_bit, eval, out_bit.
module bundler_cnt_bit
    import hdc_pkg::*;
#(
    parameter int NUM_HVS = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc_en,
    input  logic bit_in,
    input  logic tie_bit,
    input  logic eval,
    output logic out_bit
);
    localparam int CNT_W = $clog2(NUM_HVS + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(NUM_HVS / 2);
    localparam bit TIE_EN = tie_needed(NUM_HVS);

    logic [CNT_W-1:0] cnt;
    logic             tie_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            tie_q   <= 1'b0;
            out_bit <= 1'b0;
        end else begin
            // First beat of a bundle overwrites whatever the last bundle left.
            if (load) begin
                cnt   <= CNT_W'(bit_in);
                tie_q <= tie_bit;
            end else if (inc_en) begin
                cnt <= cnt + CNT_W'(bit_in);
            end
            if (eval) begin
                if (cnt > HALF)
                    out_bit <= 1'b1;
                else if (TIE_EN && cnt == HALF)
                    out_bit <= tie_q;
                else
                    out_bit <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/bundler_hv_seq.sv
// Sequential majority bundler: NUM_HVS DIM-bit HVs in, one majority HV out.
// Ports: clk, rst (sync, active-high), bus (slave), abort (only with BUNDLER_ABORT_EN).
module bundler_hv_seq
    import hdc_pkg::*;
#(
    parameter int DIM     = 64,
    parameter int NUM_HVS = 6
) (
    input  logic clk,
    input  logic rst,
`ifdef BUNDLER_ABORT_EN
    input  logic abort,
`endif
    bundler_hv_seq_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_HVS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_HVS - 1);

    bundler_state_t   state_q, state_d;
    logic [CNT_W-1:0] hv_idx_q;
    logic             abort_i;
    logic             in_ready, out_valid;
    logic             accept, out_hs;
    logic             load, inc_en, eval;
    logic [DIM-1:0]   out_hv_w;

`ifdef BUNDLER_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign accept = bus.in_valid & in_ready;
    assign out_hs = out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ACC;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC:  if (!abort_i && accept && hv_idx_q == LAST)
                      state_d = EVAL;
            EVAL: state_d = abort_i ? ACC : OUT;
            OUT:  if (out_hs)
                      state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // Handshake flags decode from state only: no in->out paths.
    always_comb begin
        in_ready  = (state_q == ACC);
        out_valid = (state_q == OUT);
        eval      = (state_q == EVAL) & ~abort_i;
        load      = accept & ~abort_i & (hv_idx_q == '0);
        inc_en    = accept & ~abort_i & (hv_idx_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst)
            hv_idx_q <= '0;
        else if (abort_i && state_q != OUT)
            hv_idx_q <= '0;
        else if (out_hs)
            hv_idx_q <= '0;
        else if (accept)
            hv_idx_q <= hv_idx_q + 1'b1;
    end

    for (genvar g = 0; g < DIM; g++) begin : g_bit
        bundler_cnt_bit #(
            .NUM_HVS(NUM_HVS)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .load   (load),
            .inc_en (inc_en),
            .bit_in (bus.in_hv[g]),
            .tie_bit(bus.tie_hv[g]),
            .eval   (eval),
            .out_bit(out_hv_w[g])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_hv    = out_hv_w;
endmodule
